mem_arbiter: RTL and testbench

- Sequential arbiter sharing one single-ported RAM between the instruction-fetch port and the data port of the MIPS core.
- Sits between the control/request logic (iREN, dREN, dWEN) and the RAM model.
- Serialises accesses and applies data-first priority with a starvation guard for fetch.
- Provides a watchdog that completes hung RAM transactions with an error indication.

---
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the instruction-fetch port
// and the data port. Writes win over reads, data wins over fetch, and a
// streak counter lets a waiting fetch in after MAX_DSTREAK back-to-back data
// grants. A watchdog force-completes an access the RAM never acknowledges.
//
// Handshake: a requester raises iREN/dREN/dWEN and holds it, together with
// its address and write data, until the matching one-cycle hit pulse. The
// RAM side sees a strobe (ramREN/ramWEN) held for the whole access and
// answers with ram_ready in the cycle the access completes; ramload is
// sampled only in that cycle.
module mem_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        ram_err,
  output logic [1:0]  state_dbg
);

  localparam logic [31:0] BAD_WORD = 32'hBAD1BAD1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DRD  = 2'd2,
    DWR  = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  dstreak;
  logic [7:0]  wd_cnt;
  logic        err_q;

  logic        in_acc;
  logic        forced;
  logic        done;
  logic        streak_full;
  logic [3:0]  streak_next;
  logic [31:0] load_val;

  // Completion detection, watchdog expiry and the streak increment value.
  always_comb begin
    in_acc      = (state != IDLE);
    forced      = in_acc && !ram_ready && (wd_cnt == 8'(TIMEOUT - 1));
    done        = in_acc && (ram_ready || forced);
    load_val    = ram_ready ? ramload : BAD_WORD;
    streak_full = (dstreak == 4'(MAX_DSTREAK));
    streak_next = streak_full ? dstreak : dstreak + 4'd1;
  end

  // RAM strobes, hits and load data decoded from state plus live requester inputs.
  always_comb begin
    ramREN    = (state == IACC) || (state == DRD);
    ramWEN    = (state == DWR);
    ramaddr   = 32'd0;
    ramstore  = 32'd0;
    if (state == IACC) ramaddr = iaddr;
    if ((state == DRD) || (state == DWR)) ramaddr = daddr;
    if (state == DWR) ramstore = dstore;
    ihit      = (state == IACC) && done && iREN;
    dhit      = ((state == DRD) && done && dREN) || ((state == DWR) && done);
    iload     = ihit ? load_val : 32'd0;
    dload     = ((state == DRD) && dhit) ? load_val : 32'd0;
    ram_err   = err_q || forced;
    state_dbg = state;
  end

  // Grant selection in IDLE, access tracking, watchdog count and sticky error.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      dstreak <= 4'd0;
      wd_cnt  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= 8'd0;
          if (dWEN) begin
            state   <= DWR;
            dstreak <= iREN ? streak_next : 4'd0;
          end else if (dREN && !(iREN && streak_full)) begin
            state   <= DRD;
            dstreak <= iREN ? streak_next : 4'd0;
          end else if (iREN) begin
            state   <= IACC;
            dstreak <= 4'd0;
          end
        end
        default: begin
          if (done) state <= IDLE;
          else      wd_cnt <= wd_cnt + 8'd1;
          if (forced) err_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, hand-written corner sequences
// (fetch with wait states, write priority, watchdog, reset mid-access) and a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int MAXD = 2;
  localparam int TO   = 8;
  localparam logic [31:0] BAD = 32'hBAD1BAD1;
  localparam logic [31:0] TLD = 32'h11112222;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN, ram_err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  mem_arbiter #(.MAX_DSTREAK(MAXD), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN),
    .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .ihit(ihit), .iload(iload),
    .dhit(dhit), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload),
    .ram_ready(ram_ready), .ram_err(ram_err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [132:0] got, input logic [132:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  task automatic clear_inputs();
    iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
  endtask

  // Leaves the bench at a falling edge with reset released.
  task automatic reset_dut();
    nRST = 0;
    clear_inputs();
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1;
  endtask

  // Vector table
  typedef struct {
    logic rst, i, d, w, rdy;
    logic e_ih, e_dh, e_ren, e_wen;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic r, logic i, logic d, logic w, logic rdy,
                              logic eih, logic edh, logic eren, logic ewen);
    vec_t v;
    v = '{r, i, d, w, rdy, eih, edh, eren, ewen};
    tbl.push_back(v);
  endfunction

  // Scoreboard / reference model state
  logic [132:0] exp_q[$];
  int   m_own, m_wait, m_streak;
  logic m_err;
  int   i_pend, d_kind;
  logic e_ih, e_dh, e_ren, e_wen, e_err, fin, frc;
  logic [31:0] e_addr, e_store, e_il, e_dl, ld;

  initial begin
    nRST = 0;
    clear_inputs();
    #2;
    check("reset_outputs",
          {ihit, dhit, ramREN, ramWEN, ram_err, state_dbg, iload, dload, ramaddr, ramstore},
          133'd0);
    reset_dut();

    // Contention: data first, then fetch once dREN drops.
    add(1, 1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 1, 1, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 1, 0, 1, 0);
    // Starvation guard with MAX_DSTREAK=2: D,D,I,D,D,I.
    add(1, 1, 1, 0, 1, 0, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      add(0, 1, 1, 0, 1, 0, 1, 1, 0);
      add(0, 1, 1, 0, 1, 0, 0, 0, 0);
      add(0, 1, 1, 0, 1, 0, 1, 1, 0);
      add(0, 1, 1, 0, 1, 0, 0, 0, 0);
      add(0, 1, 1, 0, 1, 1, 0, 1, 0);
      if (r == 0) add(0, 1, 1, 0, 1, 0, 0, 0, 0);
    end
    // Withdrawn read: DRD completes without dhit.
    add(1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].rst) reset_dut();
      iREN = tbl[k].i; dREN = tbl[k].d; dWEN = tbl[k].w;
      ram_ready = tbl[k].rdy; ramload = TLD;
      #1;
      check($sformatf("tbl%0d", k), {ihit, dhit, ramREN, ramWEN, iload, dload},
            {tbl[k].e_ih, tbl[k].e_dh, tbl[k].e_ren, tbl[k].e_wen,
             tbl[k].e_ih ? TLD : 32'd0, tbl[k].e_dh ? TLD : 32'd0});
      @(negedge CLK);
    end

    // Fetch with two RAM wait states.
    reset_dut();
    iREN = 1; iaddr = 32'h40;
    #1; check("fetch_idle", {ramREN, ihit}, 2'b00);
    @(negedge CLK);
    for (int c = 1; c <= 3; c++) begin
      ram_ready = (c == 3);
      ramload = 32'h8C220004;
      #1;
      check($sformatf("fetch_c%0d", c), {ramREN, ihit, ramaddr, iload},
            {1'b1, c == 3, 32'h40, (c == 3) ? 32'h8C220004 : 32'd0});
      @(negedge CLK);
    end
    iREN = 0; ram_ready = 0;
    #1; check("fetch_bubble", {ramREN, ihit, state_dbg}, 4'd0);
    @(negedge CLK);

    // Write priority over read.
    reset_dut();
    dWEN = 1; dREN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; ram_ready = 1;
    @(negedge CLK);
    #1;
    check("write_prio", {ramWEN, ramREN, dhit, ramaddr, ramstore},
          {3'b101, 32'h100, 32'hDEADBEEF});
    @(negedge CLK);
    dWEN = 0; dREN = 0;

    // Watchdog with TIMEOUT=8.
    reset_dut();
    dREN = 1; daddr = 32'h200; ram_ready = 0;
    @(negedge CLK);
    for (int c = 1; c <= 8; c++) begin
      #1;
      check($sformatf("wd_c%0d", c), {dhit, ramREN, ram_err, dload},
            {c == 8, 1'b1, c == 8, (c == 8) ? BAD : 32'd0});
      @(negedge CLK);
    end
    dREN = 0;
    #1; check("wd_sticky_idle", {ram_err, ramREN}, 2'b10);
    @(negedge CLK);
    iREN = 1; iaddr = 32'h44; ram_ready = 1; ramload = 32'h12345678;
    @(negedge CLK);
    #1; check("wd_sticky_access", {ihit, ram_err, iload}, {2'b11, 32'h12345678});
    @(negedge CLK);

    // Reset in the second IACC cycle.
    ram_ready = 0; ramload = 32'h55;
    @(negedge CLK);
    #1; check("rst_iacc1", {ramREN, ihit}, 2'b10);
    @(negedge CLK);
    #1; check("rst_iacc2", {ramREN, ihit, ram_err}, 3'b101);
    #1; ram_ready = 1;
    #1; check("rst_pre_hit", {ihit, iload}, {1'b1, 32'h55});
    nRST = 0;
    #1; check("rst_async", {ramREN, ihit, ram_err, iload, state_dbg}, 35'd0);
    @(negedge CLK);
    nRST = 1;
    #1; check("rst_after_idle", {ramREN, ihit, state_dbg}, 4'd0);
    @(negedge CLK);
    #1; check("rst_fresh_grant", {ramREN, ihit, ram_err}, 3'b110);
    @(negedge CLK);

    // Randomized run against the reference model.
    reset_dut();
    m_own = 0; m_wait = 0; m_streak = 0; m_err = 0;
    i_pend = 0; d_kind = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (i_pend == 0) begin
        if ($urandom_range(0, 3) == 0) begin i_pend = 1; iaddr = $urandom; end
      end else if ($urandom_range(0, 19) == 0) i_pend = 0;
      if (d_kind == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          d_kind = $urandom_range(1, 3); daddr = $urandom; dstore = $urandom;
        end
      end else if (d_kind == 1 && $urandom_range(0, 19) == 0) d_kind = 0;
      iREN = (i_pend != 0);
      dREN = (d_kind == 1) || (d_kind == 3);
      dWEN = (d_kind >= 2);
      ram_ready = ($urandom_range(0, 9) < 5);
      ramload = $urandom;

      // Expected outputs for the transaction in flight (0 none, 1 fetch, 2 read, 3 write).
      e_ih = 0; e_dh = 0; e_ren = 0; e_wen = 0;
      e_addr = 0; e_store = 0; e_il = 0; e_dl = 0;
      frc = (m_own != 0) && !ram_ready && (m_wait == TO - 1);
      fin = (m_own != 0) && (ram_ready || frc);
      ld  = ram_ready ? ramload : BAD;
      e_err = m_err || frc;
      if (m_own == 1) begin
        e_ren = 1; e_addr = iaddr; e_ih = fin && iREN; e_il = e_ih ? ld : 32'd0;
      end else if (m_own == 2) begin
        e_ren = 1; e_addr = daddr; e_dh = fin && dREN; e_dl = e_dh ? ld : 32'd0;
      end else if (m_own == 3) begin
        e_wen = 1; e_addr = daddr; e_store = dstore; e_dh = fin;
      end
      exp_q.push_back({e_ih, e_dh, e_ren, e_wen, e_err, e_addr, e_store, e_il, e_dl});
      #1;
      check($sformatf("rand%0d", cyc),
            {ihit, dhit, ramREN, ramWEN, ram_err, ramaddr, ramstore, iload, dload},
            exp_q.pop_front());
      if (e_ih) i_pend = 0;
      if (e_dh) d_kind = 0;

      // Advance the model across the clock edge.
      m_err = e_err;
      if (m_own == 0) begin
        m_wait = 0;
        if (dWEN || (dREN && !(iREN && m_streak == MAXD))) begin
          m_own = dWEN ? 3 : 2;
          m_streak = iREN ? ((m_streak + 1 > MAXD) ? MAXD : m_streak + 1) : 0;
        end else if (iREN) begin
          m_own = 1; m_streak = 0;
        end
      end else if (fin) m_own = 0;
      else m_wait++;
      @(negedge CLK);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
